// File: rtl/timeset_repeat_gen_pkg.sv
// Shared types and constant helpers for the time-set auto-repeat generator.
package timeset_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } state_e;

   typedef logic [1:0] rate_t;

   localparam rate_t RATE_SLOW  = 2'd0;
   localparam rate_t RATE_FAST  = 2'd1;
   localparam rate_t RATE_TURBO = 2'd2;

   // Rounded phase step so a 2^width accumulator overflows hz times per second.
   function automatic longint unsigned calc_inc(input longint unsigned hz,
                                                input longint unsigned sys_clk_hz,
                                                input int unsigned     width);
      return ((hz << width) + (sys_clk_hz / 64'd2)) / sys_clk_hz;
   endfunction

endpackage

// File: rtl/timeset_repeat_gen_if.sv
// Button-side and set-logic-side signals of the time-set repeat generator.
interface timeset_repeat_gen_if;
   import timeset_pkg::*;

   logic  i_en;
   logic  i_btn;
   logic  i_fast_set;
   logic  o_timeset_stb;
   rate_t o_rate;
   logic  o_active;

   modport master (output i_en, i_btn, i_fast_set,
                   input  o_timeset_stb, o_rate, o_active);
   modport slave  (input  i_en, i_btn, i_fast_set,
                   output o_timeset_stb, o_rate, o_active);
endinterface

// File: rtl/timeset_repeat_gen_rate_accumulator.sv
// Phase accumulator: adds a step each enabled cycle and emits the carry as a
// registered one-cycle strobe; the residual is kept for a true fractional divide.
module rate_accumulator #(
   parameter int unsigned ACC_WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 enable,
   input  logic [ACC_WIDTH-1:0] increment,
   output logic                 stb
);

   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH:0]   sum;

   assign sum = {1'b0, acc} + {1'b0, increment};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
         stb <= 1'b0;
      end else if (clear) begin
         acc <= '0;
         stb <= 1'b0;
      end else if (enable) begin
         acc <= sum[ACC_WIDTH-1:0];
         stb <= sum[ACC_WIDTH];
      end else begin
         stb <= 1'b0;
      end
   end

endmodule

// File: rtl/timeset_repeat_gen.sv
// Press-and-hold auto-repeat strobe generator: press strobe, hold delay, then
// repeats that escalate slow -> fast -> turbo while the button stays held.
module timeset_repeat_gen
   import timeset_pkg::*;
#(
   parameter int unsigned SYS_CLK_HZ     = 50_000_000,
   parameter int unsigned ACC_WIDTH      = 24,
   parameter int unsigned SLOW_SET_HZ    = 2,
   parameter int unsigned FAST_SET_HZ    = 5,
   parameter int unsigned TURBO_SET_HZ   = 20,
   parameter int unsigned HOLD_DELAY_MS  = 500,
   parameter int unsigned ESCALATE_COUNT = 8
) (
   input logic                 i_clk,
   input logic                 i_reset,
   timeset_repeat_gen_if.slave bus
);

   localparam int unsigned DELAY_CYCLES = SYS_CLK_HZ / 1000 * HOLD_DELAY_MS;
   localparam int unsigned DLY_W        = $clog2(DELAY_CYCLES + 1);
   localparam int unsigned ESC_W        = $clog2(ESCALATE_COUNT + 1);

   localparam longint unsigned ACC_SPAN = 64'd1 << ACC_WIDTH;
   localparam longint unsigned INC0_L   = calc_inc(64'(SLOW_SET_HZ),  64'(SYS_CLK_HZ), ACC_WIDTH);
   localparam longint unsigned INC1_L   = calc_inc(64'(FAST_SET_HZ),  64'(SYS_CLK_HZ), ACC_WIDTH);
   localparam longint unsigned INC2_L   = calc_inc(64'(TURBO_SET_HZ), 64'(SYS_CLK_HZ), ACC_WIDTH);

   if (INC0_L < 64'd1 || INC0_L >= ACC_SPAN ||
       INC1_L < 64'd1 || INC1_L >= ACC_SPAN ||
       INC2_L < 64'd1 || INC2_L >= ACC_SPAN) begin : g_bad_inc
      $error("timeset_repeat_gen: rate increment does not fit ACC_WIDTH");
   end

   localparam logic [ACC_WIDTH-1:0] INC0 = INC0_L[ACC_WIDTH-1:0];
   localparam logic [ACC_WIDTH-1:0] INC1 = INC1_L[ACC_WIDTH-1:0];
   localparam logic [ACC_WIDTH-1:0] INC2 = INC2_L[ACC_WIDTH-1:0];

   localparam logic [1:0] S_IDLE   = ST_IDLE;
   localparam logic [1:0] S_DELAY  = ST_DELAY;
   localparam logic [1:0] S_REPEAT = ST_REPEAT;

   logic [1:0]           state;
   logic                 btn_q;
   logic                 press_stb;
   logic                 acc_stb;
   logic [DLY_W-1:0]     dly;
   logic [ESC_W-1:0]     esc;
   rate_t                rate;
   rate_t                inc_rate;
   logic [ACC_WIDTH-1:0] inc;
   logic                 abort, rise, in_repeat, delay_done, escalate;

   assign abort      = !bus.i_en || !bus.i_btn;
   assign rise       = bus.i_btn && !btn_q;
   assign in_repeat  = (state == S_REPEAT);
   assign delay_done = (dly == DLY_W'(DELAY_CYCLES - 1));
   assign escalate   = in_repeat && acc_stb && (rate != RATE_TURBO) &&
                       (esc == ESC_W'(ESCALATE_COUNT - 1));

   // The add that follows an escalating strobe already runs at the new rate,
   // so spacing at each rate stays floor/ceil of its nominal period.
   assign inc_rate = escalate ? rate + 2'd1 : rate;

   always_comb begin
      case (inc_rate)
         RATE_SLOW: inc = INC0;
         RATE_FAST: inc = INC1;
         default:   inc = INC2;
      endcase
   end

   rate_accumulator #(.ACC_WIDTH(ACC_WIDTH)) u_acc (
      .clk       (i_clk),
      .rst       (i_reset),
      .clear     (abort || !in_repeat),
      .enable    (in_repeat),
      .increment (inc),
      .stb       (acc_stb)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= S_IDLE;
         btn_q     <= 1'b0;
         press_stb <= 1'b0;
         dly       <= '0;
         esc       <= '0;
         rate      <= RATE_SLOW;
      end else begin
         btn_q     <= bus.i_btn;
         press_stb <= 1'b0;
         if (abort) begin
            state <= S_IDLE;
            dly   <= '0;
            esc   <= '0;
            rate  <= RATE_SLOW;
         end else begin
            case (state)
               S_IDLE: begin
                  if (rise) begin
                     state     <= S_DELAY;
                     dly       <= '0;
                     press_stb <= 1'b1;
                  end
               end
               S_DELAY: begin
                  if (delay_done) begin
                     state     <= S_REPEAT;
                     press_stb <= 1'b1;
                     esc       <= '0;
                     rate      <= bus.i_fast_set ? RATE_FAST : RATE_SLOW;
                  end else begin
                     dly <= dly + DLY_W'(1);
                  end
               end
               S_REPEAT: begin
                  if (escalate) begin
                     rate <= inc_rate;
                     esc  <= '0;
                  end else if (acc_stb && rate != RATE_TURBO) begin
                     esc <= esc + ESC_W'(1);
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.o_timeset_stb = press_stb || acc_stb;
   assign bus.o_rate        = rate;
   assign bus.o_active      = (state != S_IDLE);

endmodule

// File: tb/tb_timeset_repeat_gen.sv
// Randomised and directed bench for timeset_repeat_gen against a phase/age model.
module tb_timeset_repeat_gen;

   localparam int SYS  = 1000;
   localparam int AW   = 16;
   localparam int HZ0  = 2;
   localparam int HZ1  = 5;
   localparam int HZ2  = 20;
   localparam int HOLD = 100;
   localparam int ESC  = 4;
   localparam int D    = SYS / 1000 * HOLD;
   localparam int FULL = 1 << AW;

   logic i_clk   = 1'b0;
   logic i_reset = 1'b0;

   timeset_repeat_gen_if bus();

   timeset_repeat_gen #(
      .SYS_CLK_HZ     (SYS),
      .ACC_WIDTH      (AW),
      .SLOW_SET_HZ    (HZ0),
      .FAST_SET_HZ    (HZ1),
      .TURBO_SET_HZ   (HZ2),
      .HOLD_DELAY_MS  (HOLD),
      .ESCALATE_COUNT (ESC)
   ) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   always #5 i_clk = ~i_clk;

   int n_chk = 0;
   int n_bad = 0;
   int cyc   = 0;
   int act_cnt;
   int inc_tab [3];
   int st_t [$];
   int st_r [$];

   // model: time since press, phase in 1/FULL units, repeats seen at this rate
   bit m_prev, m_active, m_stb, m_repstb;
   int m_age, m_phase, m_rate, m_nrep;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int clamp(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   task automatic go_idle();
      m_active = 0; m_stb = 0; m_repstb = 0;
      m_age = 0; m_phase = 0; m_rate = 0; m_nrep = 0;
   endtask

   task automatic model_reset();
      go_idle();
      m_prev = 0;
   endtask

   function automatic int eff_rate();
      if (m_repstb && m_rate < 2 && m_nrep + 1 == ESC) return m_rate + 1;
      return m_rate;
   endfunction

   function automatic bit model_will_carry();
      return m_active && (m_age >= D) && (m_phase + inc_tab[eff_rate()] >= FULL);
   endfunction

   task automatic model_step(input bit en, input bit btn, input bit fs);
      bit rise;
      int nr;
      rise   = btn && !m_prev;
      m_prev = btn;
      if (!en || !btn) begin
         go_idle();
      end else if (!m_active) begin
         m_stb    = rise;
         m_repstb = 0;
         if (rise) begin
            m_active = 1;
            m_age    = 0;
         end
      end else begin
         m_age++;
         if (m_age < D) begin
            m_stb = 0;
         end else if (m_age == D) begin
            m_stb    = 1;
            m_repstb = 0;
            m_phase  = 0;
            m_rate   = fs ? 1 : 0;
            m_nrep   = 0;
         end else begin
            nr = eff_rate();
            if (m_repstb && m_rate < 2) m_nrep = (nr != m_rate) ? 0 : m_nrep + 1;
            m_rate   = nr;
            m_phase += inc_tab[m_rate];
            m_repstb = (m_phase >= FULL);
            if (m_repstb) m_phase -= FULL;
            m_stb = m_repstb;
         end
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      if (i_reset) model_reset();
      else model_step(bus.i_en, bus.i_btn, bus.i_fast_set);
      @(negedge i_clk);
      cyc++;
      chk("stb",    bus.o_timeset_stb, m_stb);
      chk("rate",   bus.o_rate,        m_rate);
      chk("active", bus.o_active,      m_active);
      if (bus.o_active === 1'b1) act_cnt++;
      if (bus.o_timeset_stb === 1'b1) begin
         st_t.push_back(cyc);
         st_r.push_back(int'(bus.o_rate));
      end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic clear_log();
      st_t.delete();
      st_r.delete();
      act_cnt = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "bench timeout");
   end

   initial begin
      int c0, gap, lo;
      for (int r = 0; r < 3; r++)
         inc_tab[r] = (((r == 0) ? HZ0 : (r == 1) ? HZ1 : HZ2) * FULL + SYS / 2) / SYS;
      model_reset();
      bus.i_en = 1'b0; bus.i_btn = 1'b0; bus.i_fast_set = 1'b0;
      i_reset = 1'b1;
      #1;
      chk("reset_stb",    bus.o_timeset_stb, 0);
      chk("reset_rate",   bus.o_rate,        0);
      chk("reset_active", bus.o_active,      0);
      run(3);
      i_reset  = 1'b0;
      bus.i_en = 1'b1;
      run(3);

      // short press
      clear_log();
      c0 = cyc;
      bus.i_btn = 1'b1; run(10);
      bus.i_btn = 1'b0; run(5);
      chk("short_nstb", st_t.size(), 1);
      chk("short_when", st_t[0], c0 + 1);
      chk("short_act",  act_cnt, 10);

      // long hold through all three rates
      clear_log();
      bus.i_btn = 1'b1; run(3200);
      bus.i_btn = 1'b0; run(3);
      chk("long_nstb", clamp(st_t.size(), 0, 14), 14);
      for (int i = 1; i < 14 && i < st_t.size(); i++) begin
         gap = st_t[i] - st_t[i-1];
         if (i == 1) begin
            chk("gap_delay", gap, D);
         end else begin
            lo = FULL / inc_tab[(i <= 5) ? 0 : (i <= 9) ? 1 : 2];
            chk("gap_rep", gap, clamp(gap, lo, lo + 1));
            chk("rate_rep", st_r[i], (i <= 5) ? 0 : (i <= 9) ? 1 : 2);
         end
      end

      // fast-set start, toggled away mid-repeat
      clear_log();
      bus.i_fast_set = 1'b1; bus.i_btn = 1'b1; run(150);
      bus.i_fast_set = 1'b0; run(700);
      bus.i_btn = 1'b0; run(3);
      chk("fs_rate1", st_r[1], 1);
      chk("fs_rate2", st_r[2], 1);
      gap = st_t[2] - st_t[1];
      lo  = FULL / inc_tab[1];
      chk("fs_gap", gap, clamp(gap, lo, lo + 1));

      // release exactly on a predicted overflow
      bus.i_btn = 1'b1; run(700);
      for (int k = 0; k < 700 && !model_will_carry(); k++) tick();
      chk("ovf_found", model_will_carry(), 1);
      bus.i_btn = 1'b0; tick();
      chk("rel_stb",    bus.o_timeset_stb, 0);
      chk("rel_rate",   bus.o_rate,        0);
      chk("rel_active", bus.o_active,      0);
      run(2);

      // enable dropped mid-repeat, raised again with button still held
      bus.i_btn = 1'b1; run(700);
      clear_log();
      bus.i_en = 1'b0; run(20);
      bus.i_en = 1'b1; run(40);
      chk("en_nstb", st_t.size(), 0);
      chk("en_act",  act_cnt,     0);
      bus.i_btn = 1'b0; tick();
      bus.i_btn = 1'b1; tick();
      chk("en_repress", bus.o_timeset_stb, 1);
      bus.i_btn = 1'b0; run(3);

      // asynchronous reset mid-delay with button held
      bus.i_btn = 1'b1; run(30);
      #2 i_reset = 1'b1;
      #1;
      chk("arst_stb",    bus.o_timeset_stb, 0);
      chk("arst_rate",   bus.o_rate,        0);
      chk("arst_active", bus.o_active,      0);
      model_reset();
      run(2);
      i_reset = 1'b0;
      tick();
      chk("arst_press", bus.o_timeset_stb, 1);
      run(5);
      bus.i_btn = 1'b0; run(3);

      // randomised holds, releases, enable drops and fast-set
      for (int s = 0; s < 10; s++) begin
         bus.i_en       = ($urandom_range(0, 7) != 0);
         bus.i_fast_set = $urandom_range(0, 1);
         bus.i_btn      = 1'b1;
         run($urandom_range(1, 1200));
         bus.i_en       = 1'b1;
         bus.i_btn      = 1'b0;
         run($urandom_range(1, 4));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/timeset_repeat_gen.md
# timeset_repeat_gen

Press-and-hold auto-repeat strobe generator for the clock's time-set buttons. It emits one strobe immediately on press, a second after a hold delay, then repeats at a rate that escalates through three speeds (slow, fast, turbo) while the button stays held. It sits between the debounced button inputs and the hours/minutes set logic, and is the multi-rate, hold-aware successor to the fixed two-rate time-set divider.

## Interface
- SYS_CLK_HZ, 50_000_000: system clock frequency.
- ACC_WIDTH, 24: phase-accumulator width in bits.
- SLOW_SET_HZ, 2: repeat rate 0.
- FAST_SET_HZ, 5: repeat rate 1.
- TURBO_SET_HZ, 20: repeat rate 2.
- HOLD_DELAY_MS, 500: delay from press strobe to first repeat strobe.
- ESCALATE_COUNT, 8: repeat strobes emitted at a rate before stepping to the next rate.
- i_clk  in  1  system clock. This is the only clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_en  in  1  enable. Low forces IDLE.
- i_btn  in  1  debounced, synchronised button level. High means held.
- i_fast_set  in  1  when high, REPEAT starts at rate 1 instead of rate 0.
- o_timeset_stb  out  1  single-cycle increment strobe.
- o_rate  out  2  current repeat rate index: 0, 1 or 2.
- o_active  out  1  high while state is not IDLE.

## Operation
- States:
  - IDLE: accumulator = 0, rate = 0, escalation count = 0.
  - DELAY: hold-delay counter is running.
  - REPEAT: accumulator is running.
- Transitions:
  - IDLE→DELAY: on a rising edge of i_btn (previous sample 0, current sample 1) with i_en=1. Emit the press strobe.
  - DELAY→REPEAT: when the delay counter reaches DELAY_CYCLES = SYS_CLK_HZ/1000*HOLD_DELAY_MS. Emit a strobe. Clear the accumulator. Set rate = i_fast_set ? 1 : 0.
  - Any state→IDLE: when i_btn=0 or i_en=0. Takes priority over every other event in the same cycle, so no strobe is emitted that cycle.
- Increment for rate r: INC_r = round(2^ACC_WIDTH × HZ_r / SYS_CLK_HZ).
  - Width check (elaboration error if violated): 1 ≤ INC_r < 2^ACC_WIDTH.
  - Each REPEAT cycle: {carry, acc} = acc + INC_rate, with ACC_WIDTH+1 bits. carry=1 produces a strobe. The residual is kept (true fractional divide).
- Escalation:
  - Each REPEAT strobe increments the escalation count.
  - On the ESCALATE_COUNT-th strobe at rate r<2: rate ← r+1, count ← 0. The accumulator residual is not cleared.
  - Rate 2 saturates and the count stops.
- If i_fast_set changes mid-REPEAT it is ignored. It is sampled only on DELAY→REPEAT.
- Delay counter width: $clog2(DELAY_CYCLES+1).
- Escalation counter width: $clog2(ESCALATE_COUNT+1).

## Timing
- Reset values: o_timeset_stb=0, o_rate=0, o_active=0, state=IDLE, all counters 0. The previous-i_btn register also resets to 0, so a button held through reset release produces a press strobe.
- o_timeset_stb is registered and always exactly one cycle wide.
- Press latency: rising edge sampled at edge N → strobe high during cycle N+1. o_active rises in the same cycle.
- First repeat strobe arrives DELAY_CYCLES cycles after the press strobe.
- After that, successive strobes at rate r are spaced floor or ceil of 2^ACC_WIDTH/INC_r cycles.
- o_rate updates in the cycle after the escalating strobe.
- Release: i_btn sampled 0 at edge N → o_active=0 and o_rate=0 in cycle N+1, with no strobe in N+1.
- Re-press produces a fresh press strobe. There is no minimum gap beyond one low sample.
- Asynchronous reset mid-REPEAT clears everything immediately. No strobe is emitted during or after reset until the next qualified rising edge.

## Structure
- Package timeset_pkg:
  - state enum (IDLE, DELAY, REPEAT)
  - 2-bit rate index type
  - constant function computing INC from (hz, sys_clk_hz, width)
- Sub-module rate_accumulator: ACC_WIDTH phase accumulator.
  - Inputs: clear, enable, increment.
  - Output: registered single-cycle carry strobe.
- The top level holds the FSM, the delay counter, the escalation counter and the edge detector.

## Test plan
Bench parameters: SYS_CLK_HZ=1000, ACC_WIDTH=16, rates 2/5/20 (INC=131/328/1311), HOLD_DELAY_MS=100 (100 cycles), ESCALATE_COUNT=4.
- Short press: assert i_btn for 10 cycles → exactly one strobe, one cycle after the edge; o_active high for 10 cycles; then 0.
- Long hold:
  - Strobe at press; next strobe 100 cycles later.
  - Then 4 strobes spaced 500/501 cycles with o_rate=0.
  - Then 4 strobes spaced 199/200 with o_rate=1.
  - Then a steady 49/50 spacing with o_rate=2.
- i_fast_set=1 during hold → REPEAT starts at o_rate=1 with 199/200 spacing. Toggling i_fast_set later has no effect.
- Release coincident with a predicted overflow cycle → no strobe; o_rate=0 and o_active=0 the next cycle.
- i_en dropped mid-REPEAT → IDLE, no strobes. Raising i_en with i_btn still high gives no strobe until a new rising edge.
- Reset pulse mid-DELAY:
  - All outputs 0 immediately.
  - After release with i_btn held high, the press strobe appears one cycle after the first clock edge.
